led_pattern_ctrl: RTL and testbench

- Controller that owns the 8-LED bar and sequences it through selectable animation patterns: bounce scan, rotate, fill, blink.
- Contains a programmable tick prescaler, a pattern-step datapath and a small run/pause/load FSM.
- A valid/ready command port reconfigures mode and speed at runtime.
- Sits between the board top level (or a button/UART command source) and the `led` pins.

---
 rtl/led_pkg.sv | 38 +++
 rtl/led_tick_gen.sv | 42 ++++
 rtl/led_pattern_ctrl.sv | 146 ++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern controller: mode codes, pattern
// seeds, controller FSM states and the LED bar width.
package led_pkg;

  localparam int unsigned LED_W = 8;

  typedef enum logic [1:0] {
    MODE_SCAN   = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_FILL   = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_LOAD   = 2'd2
  } state_t;

  localparam logic [LED_W-1:0] SEED_SCAN   = 8'h01;
  localparam logic [LED_W-1:0] SEED_ROTATE = 8'h01;
  localparam logic [LED_W-1:0] SEED_FILL   = 8'h00;
  localparam logic [LED_W-1:0] SEED_BLINK  = 8'h55;

  // Starting LED pattern for a mode.
  function automatic logic [LED_W-1:0] mode_seed(input mode_t m);
    logic [LED_W-1:0] s;
    case (m)
      MODE_SCAN:   s = SEED_SCAN;
      MODE_ROTATE: s = SEED_ROTATE;
      MODE_FILL:   s = SEED_FILL;
      MODE_BLINK:  s = SEED_BLINK;
      default:     s = SEED_SCAN;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Programmable step prescaler. Counts while enabled and pulses tick
// (combinationally) in the cycle the count reaches the limit, which is the
// all-ones value shifted right by div; period is therefore limit+1 cycles.
module led_tick_gen #(
  parameter int unsigned CTR_WIDTH = 20
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       en,
  input  logic       clr,
  input  logic [3:0] div,
  output logic       tick
);

  localparam logic [CTR_WIDTH-1:0] CTR_ALL1 = '1;

  logic [CTR_WIDTH-1:0] ctr;
  logic [CTR_WIDTH-1:0] limit;

  // Wrap limit for the selected divider.
  always_comb begin
    limit = CTR_ALL1 >> div;
  end

  assign tick = en && (ctr == limit);

  // Counter: clears on clr, advances only when enabled, wraps at the limit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ctr <= '0;
    end else if (clr) begin
      ctr <= '0;
    end else if (en) begin
      if (ctr == limit) begin
        ctr <= '0;
      end else begin
        ctr <= ctr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED bar animation controller: run/pause/load FSM, pattern step datapath
// and a valid/ready command port selecting mode and speed at runtime.
module led_pattern_ctrl #(
  parameter int unsigned CTR_WIDTH    = 20,
  parameter int unsigned DEFAULT_MODE = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd_mode,
  input  logic [3:0] i_cmd_div,
  input  logic       i_pause,
  output logic [7:0] led,
  output logic       o_tick,
  output logic [1:0] o_mode
);

  import led_pkg::*;

  localparam mode_t RST_MODE = mode_t'(2'(DEFAULT_MODE));

  state_t     state;
  state_t     state_nxt;
  mode_t      mode_q;
  mode_t      pend_mode;
  logic [3:0] div_q;
  logic [3:0] pend_div;
  logic [3:0] div_clamped;
  logic       dir_q;
  logic       accept;
  logic       tick;
  logic [7:0] step_led;
  logic       step_dir;

  assign accept = i_cmd_valid & o_cmd_ready;
  assign o_mode = mode_q;

  led_tick_gen #(
    .CTR_WIDTH(CTR_WIDTH)
  ) u_tick_gen (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .en   (state == ST_RUN),
    .clr  (state == ST_LOAD),
    .div  (div_q),
    .tick (tick)
  );

  // Limit the requested divider so the period never drops below 2 cycles.
  always_comb begin
    div_clamped = i_cmd_div;
    if (32'(i_cmd_div) > CTR_WIDTH - 1) begin
      div_clamped = 4'(CTR_WIDTH - 1);
    end
  end

  // Next LED value and scan direction for the active mode.
  always_comb begin
    step_led = led;
    step_dir = dir_q;
    case (mode_q)
      MODE_SCAN: begin
        if (!dir_q) begin
          if (led[7]) begin
            step_dir = 1'b1;
            step_led = led >> 1;
          end else begin
            step_led = led << 1;
          end
        end else begin
          if (led[0]) begin
            step_dir = 1'b0;
            step_led = led << 1;
          end else begin
            step_led = led >> 1;
          end
        end
      end
      MODE_ROTATE: step_led = {led[6:0], led[7]};
      MODE_FILL:   step_led = (led == 8'hFF) ? 8'h00 : {led[6:0], 1'b1};
      MODE_BLINK:  step_led = ~led;
      default:     step_led = led;
    endcase
  end

  // FSM next state: a command always wins; LOAD lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (accept)       state_nxt = ST_LOAD;
        else if (i_pause) state_nxt = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (accept)        state_nxt = ST_LOAD;
        else if (!i_pause) state_nxt = ST_RUN;
      end
      ST_LOAD: state_nxt = i_pause ? ST_PAUSED : ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath: capture commands, apply them in LOAD, otherwise step on tick.
  // The command is parked in pend_* on accept so o_mode and led both switch
  // together at the LOAD edge; an accept masks a coincident tick.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      led         <= mode_seed(RST_MODE);
      mode_q      <= RST_MODE;
      pend_mode   <= RST_MODE;
      div_q       <= '0;
      pend_div    <= '0;
      dir_q       <= 1'b0;
      o_tick      <= 1'b0;
      o_cmd_ready <= 1'b0;
    end else begin
      o_cmd_ready <= (state_nxt != ST_LOAD);
      o_tick      <= 1'b0;
      if (accept) begin
        pend_mode <= mode_t'(i_cmd_mode);
        pend_div  <= div_clamped;
      end
      if (state == ST_LOAD) begin
        mode_q <= pend_mode;
        div_q  <= pend_div;
        led    <= mode_seed(pend_mode);
        dir_q  <= 1'b0;
      end else if (!accept && tick) begin
        led    <= step_led;
        dir_q  <= step_dir;
        o_tick <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl with CTR_WIDTH=2 (base period 4).
// Expected LED steps and the clock cycle each must land on are queued when a
// command or release is driven; a monitor pops them on every o_tick.
module tb_led_pattern_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_cmd_valid = 1'b0;
  logic       o_cmd_ready;
  logic [1:0] i_cmd_mode = 2'd0;
  logic [3:0] i_cmd_div = 4'd0;
  logic       i_pause = 1'b0;
  logic [7:0] led;
  logic       o_tick;
  logic [1:0] o_mode;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [7:0]  led;
    int unsigned cyc;
  } sb_t;
  sb_t sb[$];

  // Vector record: command inputs plus expected seed, period and steps
  // (step k is in byte k, step 0 in the low byte).
  typedef struct {
    logic [1:0]   mode;
    logic [3:0]   div;
    logic [7:0]   seed;
    int unsigned  period;
    int unsigned  nsteps;
    logic [127:0] steps;
  } vec_t;
  vec_t vecs[4];
  vec_t scan0;

  led_pattern_ctrl #(
    .CTR_WIDTH(2),
    .DEFAULT_MODE(0)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready),
    .i_cmd_mode(i_cmd_mode),
    .i_cmd_div(i_cmd_div),
    .i_pause(i_pause),
    .led(led),
    .o_tick(o_tick),
    .o_mode(o_mode)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic next_cyc();
    @(negedge i_clk);
    #1;
  endtask

  task automatic push_steps(input vec_t v, input int unsigned base);
    for (int unsigned k = 0; k < v.nsteps; k++) begin
      sb.push_back('{led: v.steps[8*k +: 8], cyc: base + (k + 1) * v.period});
    end
  endtask

  task automatic wait_empty(input int unsigned limit);
    int unsigned n = 0;
    while (sb.size() != 0 && n < limit) begin
      next_cyc();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL tick_timeout: %0d expected steps never arrived (cycle %0d)", sb.size(), cyc);
      sb.delete();
    end
  endtask

  // Issue one command; returns the clock edge number that accepted it.
  task automatic send_cmd(input logic [1:0] m, input logic [3:0] d,
                          input logic [7:0] seed, output int unsigned acc);
    int unsigned n = 0;
    while (!o_cmd_ready && n < 10) begin
      next_cyc();
      n++;
    end
    chk("cmd_ready_before", 32'(o_cmd_ready), 32'd1);
    i_cmd_valid = 1'b1;
    i_cmd_mode  = m;
    i_cmd_div   = d;
    next_cyc();
    acc = cyc;
    i_cmd_valid = 1'b0;
    chk("cmd_ready_load", 32'(o_cmd_ready), 32'd0);
    next_cyc();
    chk("load_seed", 32'(led), 32'(seed));
    chk("load_mode", 32'(o_mode), 32'(m));
    chk("cmd_ready_after", 32'(o_cmd_ready), 32'd1);
  endtask

  // Scoreboard monitor: every o_tick must match the next queued step.
  always @(negedge i_clk) begin : monitor
    sb_t e;
    if (!i_rst && o_tick) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick: led=%02h at cycle %0d, no step expected", led, cyc);
      end else begin
        e = sb.pop_front();
        chk("tick_led", 32'(led), 32'(e.led));
        chk("tick_cycle", e.cyc, cyc);
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a;
    int unsigned base;

    scan0   = '{mode: 2'd0, div: 4'd0, seed: 8'h01, period: 4, nsteps: 15,
                steps: 128'h020102040810204080402010080402};
    vecs[0] = '{mode: 2'd2, div: 4'd0, seed: 8'h00, period: 4, nsteps: 9,
                steps: 128'h00FF7F3F1F0F070301};
    vecs[1] = '{mode: 2'd3, div: 4'd7, seed: 8'h55, period: 2, nsteps: 4,
                steps: 128'h55AA55AA};
    vecs[2] = '{mode: 2'd1, div: 4'd1, seed: 8'h01, period: 2, nsteps: 9,
                steps: 128'h020180402010080402};
    vecs[3] = '{mode: 2'd1, div: 4'd15, seed: 8'h01, period: 2, nsteps: 3,
                steps: 128'h080402};

    // Reset state.
    #12;
    chk("rst_led", 32'(led), 32'h01);
    chk("rst_mode", 32'(o_mode), 32'd0);
    chk("rst_ready", 32'(o_cmd_ready), 32'd0);
    chk("rst_tick", 32'(o_tick), 32'd0);
    next_cyc();
    i_rst = 1'b0;
    base = cyc;
    push_steps(scan0, base);
    chk("ready_at_release", 32'(o_cmd_ready), 32'd0);
    next_cyc();
    chk("ready_first_edge", 32'(o_cmd_ready), 32'd1);
    wait_empty(100);

    // Table of mode/speed commands.
    for (int i = 0; i < 4; i++) begin
      send_cmd(vecs[i].mode, vecs[i].div, vecs[i].seed, a);
      push_steps(vecs[i], a + 1);
      wait_empty(100);
    end

    // Valid held high: accepted every second cycle.
    i_cmd_valid = 1'b1;
    i_cmd_mode  = 2'd1;
    i_cmd_div   = 4'd0;
    next_cyc();
    chk("b2b_ready_0", 32'(o_cmd_ready), 32'd0);
    next_cyc();
    chk("b2b_ready_1", 32'(o_cmd_ready), 32'd1);
    next_cyc();
    chk("b2b_ready_2", 32'(o_cmd_ready), 32'd0);
    next_cyc();
    chk("b2b_ready_3", 32'(o_cmd_ready), 32'd1);
    chk("b2b_led", 32'(led), 32'h01);
    i_cmd_valid = 1'b0;
    base = cyc;
    sb.push_back('{led: 8'h02, cyc: base + 4});
    sb.push_back('{led: 8'h04, cyc: base + 8});
    sb.push_back('{led: 8'h08, cyc: base + 12});
    wait_empty(40);

    // Pause mid-count for 10 cycles; the step lands after the remaining count.
    next_cyc();
    next_cyc();
    i_pause = 1'b1;
    repeat (10) next_cyc();
    chk("pause_led", 32'(led), 32'h08);
    i_pause = 1'b0;
    sb.push_back('{led: 8'h10, cyc: cyc + 2});
    wait_empty(20);

    // Pause raised in the wrap cycle: the step still happens, then hold.
    repeat (3) next_cyc();
    i_pause = 1'b1;
    sb.push_back('{led: 8'h20, cyc: cyc + 1});
    wait_empty(10);
    repeat (3) next_cyc();
    chk("pause_wrap_led", 32'(led), 32'h20);

    // Command accepted while paused: new seed shown, then frozen.
    send_cmd(2'd3, 4'd0, 8'h55, a);
    repeat (5) next_cyc();
    chk("paused_after_load", 32'(led), 32'h55);
    i_pause = 1'b0;
    sb.push_back('{led: 8'hAA, cyc: cyc + 5});
    wait_empty(20);

    // Command in the exact wrap cycle: no tick, seed at the next edge.
    send_cmd(2'd0, 4'd0, 8'h01, a);
    repeat (3) next_cyc();
    i_cmd_valid = 1'b1;
    i_cmd_mode  = 2'd2;
    i_cmd_div   = 4'd0;
    next_cyc();
    i_cmd_valid = 1'b0;
    chk("collide_tick", 32'(o_tick), 32'd0);
    chk("collide_led", 32'(led), 32'h01);
    next_cyc();
    chk("collide_seed", 32'(led), 32'h00);
    chk("collide_mode", 32'(o_mode), 32'd2);
    base = cyc;
    sb.push_back('{led: 8'h01, cyc: base + 4});
    sb.push_back('{led: 8'h03, cyc: base + 8});
    sb.push_back('{led: 8'h07, cyc: base + 12});
    wait_empty(30);

    // Asynchronous reset pulse between clock edges.
    #1 i_rst = 1'b1;
    #1;
    chk("async_led", 32'(led), 32'h01);
    chk("async_mode", 32'(o_mode), 32'd0);
    chk("async_ready", 32'(o_cmd_ready), 32'd0);
    chk("async_tick", 32'(o_tick), 32'd0);
    #1 i_rst = 1'b0;
    base = cyc;
    sb.push_back('{led: 8'h02, cyc: base + 4});
    next_cyc();
    chk("post_rst_ready", 32'(o_cmd_ready), 32'd1);
    wait_empty(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
